// File: rtl/cdb_arbiter.sv
// Result-bus arbiter: queues ALU and LSB completions in per-source FIFOs and
// drives one registered common data bus with round-robin arbitration.
module cdb_arbiter #(
  parameter int ROB_ID_W   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                alu_valid,
  input  logic [31:0]         alu_value,
  input  logic [ROB_ID_W-1:0] alu_robid,
  input  logic [31:0]         alu_topc,
  output logic                alu_ready,
  input  logic                lsb_valid,
  input  logic [31:0]         lsb_value,
  input  logic [ROB_ID_W-1:0] lsb_robid,
  output logic                lsb_ready,
  output logic                cdb_valid,
  output logic [31:0]         cdb_value,
  output logic [ROB_ID_W-1:0] cdb_robid,
  output logic [31:0]         cdb_topc,
  output logic                cdb_src,
  output logic                err_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;
  localparam logic [31:0] SEQ_PC = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0]         value;
    logic [ROB_ID_W-1:0] robid;
    logic [31:0]         topc;
  } alu_entry_t;

  typedef struct packed {
    logic [31:0]         value;
    logic [ROB_ID_W-1:0] robid;
  } lsb_entry_t;

  alu_entry_t alu_mem [FIFO_DEPTH];
  lsb_entry_t lsb_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] alu_head, alu_tail, lsb_head, lsb_tail;
  logic [CNT_W-1:0] alu_count, lsb_count;
  logic             last_grant;

  logic advance;
  logic alu_push, lsb_push, alu_pop, lsb_pop;
  logic grant_alu, grant_lsb;
  logic overflow_now;

  // Handshake: an input is taken on a clk edge only when valid and ready are
  // both high (and the block advances); ready never depends on valid or on a
  // same-cycle pop, so a full FIFO refuses input for the whole cycle.
  assign alu_ready = (alu_count < DEPTH_C);
  assign lsb_ready = (lsb_count < DEPTH_C);

  always_comb begin
    advance      = rdy && !flush;
    alu_push     = advance && alu_valid && alu_ready;
    lsb_push     = advance && lsb_valid && lsb_ready;
    grant_alu    = (alu_count != '0) && ((lsb_count == '0) || (last_grant == SRC_LSB));
    grant_lsb    = (lsb_count != '0) && !grant_alu;
    alu_pop      = advance && grant_alu;
    lsb_pop      = advance && grant_lsb;
    overflow_now = advance && ((alu_valid && !alu_ready) || (lsb_valid && !lsb_ready));
  end

  // Storage needs no reset: occupancy is tracked entirely by the counters.
  always_ff @(posedge clk) begin
    if (alu_push) alu_mem[alu_tail] <= '{value: alu_value, robid: alu_robid, topc: alu_topc};
    if (lsb_push) lsb_mem[lsb_tail] <= '{value: lsb_value, robid: lsb_robid};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      alu_head  <= '0;
      alu_tail  <= '0;
      alu_count <= '0;
      lsb_head  <= '0;
      lsb_tail  <= '0;
      lsb_count <= '0;
    end else if (rdy) begin
      if (alu_push) alu_tail <= alu_tail + PTR_ONE;
      if (alu_pop)  alu_head <= alu_head + PTR_ONE;
      if (lsb_push) lsb_tail <= lsb_tail + PTR_ONE;
      if (lsb_pop)  lsb_head <= lsb_head + PTR_ONE;
      case ({alu_push, alu_pop})
        2'b10:   alu_count <= alu_count + CNT_ONE;
        2'b01:   alu_count <= alu_count - CNT_ONE;
        default: alu_count <= alu_count;
      endcase
      case ({lsb_push, lsb_pop})
        2'b10:   lsb_count <= lsb_count + CNT_ONE;
        2'b01:   lsb_count <= lsb_count - CNT_ONE;
        default: lsb_count <= lsb_count;
      endcase
    end
  end

  // Reset leaves last_grant at LSB so the ALU wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= SRC_LSB;
      err_overflow <= 1'b0;
      cdb_valid    <= 1'b0;
      cdb_value    <= '0;
      cdb_robid    <= '0;
      cdb_topc     <= SEQ_PC;
      cdb_src      <= SRC_ALU;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (rdy) begin
      if (overflow_now) err_overflow <= 1'b1;
      if (grant_alu) begin
        last_grant <= SRC_ALU;
        cdb_valid  <= 1'b1;
        cdb_value  <= alu_mem[alu_head].value;
        cdb_robid  <= alu_mem[alu_head].robid;
        cdb_topc   <= alu_mem[alu_head].topc;
        cdb_src    <= SRC_ALU;
      end else if (grant_lsb) begin
        last_grant <= SRC_LSB;
        cdb_valid  <= 1'b1;
        cdb_value  <= lsb_mem[lsb_head].value;
        cdb_robid  <= lsb_mem[lsb_head].robid;
        cdb_topc   <= SEQ_PC;
        cdb_src    <= SRC_LSB;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: each step drives inputs, advances one edge
// and compares the registered bus against hand-computed expectations.
module tb_cdb_arbiter;

  localparam int ROB_ID_W   = 4;
  localparam int FIFO_DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst, rdy, flush;
  logic                alu_valid, lsb_valid;
  logic [31:0]         alu_value, alu_topc, lsb_value;
  logic [ROB_ID_W-1:0] alu_robid, lsb_robid;
  logic                alu_ready, lsb_ready;
  logic                cdb_valid, cdb_src, err_overflow;
  logic [31:0]         cdb_value, cdb_topc;
  logic [ROB_ID_W-1:0] cdb_robid;

  int checks = 0;
  int errors = 0;

  // Per-edge expectations for the overflow scenario: valid, src, robid.
  int t3_v   [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int t3_src [12] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
  int t3_rid [12] = '{0, 0, 8, 1, 9, 2, 10, 3, 4, 5, 6, 0};

  cdb_arbiter #(.ROB_ID_W(ROB_ID_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alu_valid(alu_valid), .alu_value(alu_value), .alu_robid(alu_robid),
    .alu_topc(alu_topc), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_value(lsb_value), .lsb_robid(lsb_robid),
    .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_robid(cdb_robid),
    .cdb_topc(cdb_topc), .cdb_src(cdb_src), .err_overflow(err_overflow)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic drive_alu(input int value, input int rid, input int topc);
    alu_valid = 1'b1;
    alu_value = 32'(value);
    alu_robid = ROB_ID_W'(rid);
    alu_topc  = 32'(topc);
  endtask

  task automatic drive_lsb(input int value, input int rid);
    lsb_valid = 1'b1;
    lsb_value = 32'(value);
    lsb_robid = ROB_ID_W'(rid);
  endtask

  task automatic do_reset();
    idle();
    rdy = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cdb(input string tag, input int v, input int src, input int rid);
    chk({tag, "_valid"}, 32'(cdb_valid), 32'(v));
    if (v != 0) begin
      chk({tag, "_src"}, 32'(cdb_src), 32'(src));
      chk({tag, "_robid"}, 32'(cdb_robid), 32'(rid));
    end
  endtask

  initial begin
    int idx;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    alu_valid = 1'b0; lsb_valid = 1'b0;
    alu_value = '0; alu_topc = '0; lsb_value = '0;
    alu_robid = '0; lsb_robid = '0;
    tick();
    tick();
    chk("rst_valid", 32'(cdb_valid), 32'd0);
    chk("rst_value", cdb_value, 32'd0);
    chk("rst_robid", 32'(cdb_robid), 32'd0);
    chk("rst_topc", cdb_topc, 32'hFFFF_FFFF);
    chk("rst_src", 32'(cdb_src), 32'd0);
    chk("rst_err", 32'(err_overflow), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_lsb_ready", 32'(lsb_ready), 32'd1);
    rst = 1'b0;

    // Single ALU result: push edge, broadcast edge, idle edge
    drive_alu(5, 3, 32'h1000);
    tick();
    idle();
    chk("t1_push_edge_valid", 32'(cdb_valid), 32'd0);
    tick();
    chk_cdb("t1_bcast", 1, 0, 3);
    chk("t1_value", cdb_value, 32'd5);
    chk("t1_topc", cdb_topc, 32'h1000);
    tick();
    chk("t1_drop_valid", 32'(cdb_valid), 32'd0);
    chk("t1_hold_value", cdb_value, 32'd5);

    // Dual load for 6 cycles, then drain: strict ALU/LSB alternation
    do_reset();
    for (int k = 0; k < 13; k++) begin
      if (k < 6) begin
        drive_alu(100 + k, k, 32'h2000 + k);
        drive_lsb(200 + k, 8 + k);
      end else begin
        idle();
      end
      tick();
      if (k == 5) chk("t2_lsb_full", 32'(lsb_ready), 32'd0);
      if (k == 0) begin
        chk("t2_first_edge_valid", 32'(cdb_valid), 32'd0);
      end else begin
        idx = (k - 1) / 2;
        if (((k - 1) % 2) == 0) begin
          chk_cdb("t2_alu", 1, 0, idx);
          chk("t2_alu_value", cdb_value, 32'(100 + idx));
          chk("t2_alu_topc", cdb_topc, 32'(32'h2000 + idx));
        end else begin
          chk_cdb("t2_lsb", 1, 1, 8 + idx);
          chk("t2_lsb_value", cdb_value, 32'(200 + idx));
          chk("t2_lsb_topc", cdb_topc, 32'hFFFF_FFFF);
        end
      end
    end
    tick();
    chk("t2_drained", 32'(cdb_valid), 32'd0);

    // ALU FIFO fills while LSB competes; 5th-in-excess push (robid 7) dropped
    do_reset();
    for (int k = 0; k < 12; k++) begin
      idle();
      if (k < 8) drive_alu(300 + k, k, 0);
      if (k < 3) drive_lsb(400 + k, 8 + k);
      tick();
      chk_cdb("t3_seq", t3_v[k], t3_src[k], t3_rid[k]);
      if (k == 6) begin
        chk("t3_alu_full", 32'(alu_ready), 32'd0);
        chk("t3_err_before", 32'(err_overflow), 32'd0);
      end
      if (k == 7) begin
        chk("t3_err_set", 32'(err_overflow), 32'd1);
        chk("t3_alu_ready_again", 32'(alu_ready), 32'd1);
      end
    end
    chk("t3_err_sticky", 32'(err_overflow), 32'd1);

    // Flush with 3 entries in each FIFO and a push on the flush edge
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_alu(500 + k, k, 0);
      drive_lsb(600 + k, 8 + k);
      tick();
    end
    chk_cdb("t4_pre_flush", 1, 1, 9);
    idle();
    flush = 1'b1;
    drive_alu(700, 15, 0);
    tick();
    idle();
    chk("t4_flush_valid", 32'(cdb_valid), 32'd0);
    tick();
    chk("t4_empty1", 32'(cdb_valid), 32'd0);
    tick();
    chk("t4_empty2", 32'(cdb_valid), 32'd0);
    chk("t4_alu_ready", 32'(alu_ready), 32'd1);
    chk("t4_lsb_ready", 32'(lsb_ready), 32'd1);
    drive_alu(800, 12, 0);
    tick();
    idle();
    chk("t4_push_edge", 32'(cdb_valid), 32'd0);
    tick();
    chk_cdb("t4_after", 1, 0, 12);
    chk("t4_after_value", cdb_value, 32'd800);
    tick();
    chk("t4_no_flushed_push", 32'(cdb_valid), 32'd0);
    chk("t4_err", 32'(err_overflow), 32'd0);

    // rdy low for 3 edges while robid 7 is on the bus
    do_reset();
    drive_alu(70, 7, 0);
    drive_lsb(90, 9);
    tick();
    idle();
    drive_alu(10, 1, 0);
    tick();
    idle();
    chk_cdb("t5_start", 1, 0, 7);
    rdy = 1'b0;
    drive_alu(20, 2, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_cdb("t5_frozen", 1, 0, 7);
      chk("t5_frozen_value", cdb_value, 32'd70);
    end
    idle();
    rdy = 1'b1;
    tick();
    chk_cdb("t5_resume_lsb", 1, 1, 9);
    tick();
    chk_cdb("t5_resume_alu", 1, 0, 1);
    tick();
    chk("t5_no_push_while_frozen", 32'(cdb_valid), 32'd0);
    chk("t5_err", 32'(err_overflow), 32'd0);

    // 10 sequential ALU entries wrap the pointers
    do_reset();
    for (int k = 0; k < 11; k++) begin
      if (k < 10) drive_alu(k * 32'h0101_0101, k, 32'h4000 + 4 * k);
      else idle();
      tick();
      if (k >= 1) begin
        chk_cdb("t6_wrap", 1, 0, k - 1);
        chk("t6_value", cdb_value, 32'((k - 1) * 32'h0101_0101));
        chk("t6_topc", cdb_topc, 32'(32'h4000 + 4 * (k - 1)));
      end
    end
    tick();
    chk("t6_done", 32'(cdb_valid), 32'd0);

    // Reset in the middle of a burst
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_alu(900 + k, k, 0);
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_valid", 32'(cdb_valid), 32'd0);
    chk("t7_rst_value", cdb_value, 32'd0);
    chk("t7_rst_topc", cdb_topc, 32'hFFFF_FFFF);
    tick();
    chk("t7_no_bcast", 32'(cdb_valid), 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
